// File: rtl/ipv4_decode.sv
// ipv4_decode: receive-side IPv4 header parser that forwards accepted payload bytes to tcp_decode.
// Build option: define IPV4_CHECKSUM_EN to verify the header checksum; otherwise the field is ignored.
module ipv4_decode #(
    parameter logic [31:0] LOCAL_IP = 32'hC0A80164
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [7:0]  din,
    input  logic        last,
    output logic        out_valid,
    output logic [7:0]  dout,
    output logic        out_last,
    output logic [31:0] src_ip,
    output logic [31:0] dst_ip,
    output logic [15:0] total_len,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_HEADER,
        S_OPTIONS,
        S_PAYLOAD,
        S_PAD,
        S_DROP
    } state_t;

    localparam logic [31:0] BCAST_IP = 32'hFFFFFFFF;
    localparam logic [15:0] CNT_MAX  = 16'hFFFF;

    state_t      r_state;
    state_t      w_next;

    logic [15:0] r_cnt;
    logic [3:0]  r_ihl;
    logic [5:0]  r_frag_hi;
    logic [31:0] r_src;
    logic [31:0] r_dst;
    logic [15:0] r_tlen;

    logic        r_out_valid;
    logic [7:0]  r_dout;
    logic        r_out_last;
    logic        r_done;
    logic        r_err;

    logic        w_in_hdr;
    logic [15:0] w_hdr_len;
    logic        w_hdr_final;
    logic        w_no_payload;
    logic        w_payload_end;
    logic [31:0] w_dst_full;
    logic        w_check_fail;
    logic        w_csum_fail;

    logic        w_out_valid;
    logic        w_out_last;
    logic        w_done;
    logic        w_err;

    assign w_in_hdr      = (r_state == S_HEADER) || (r_state == S_OPTIONS);
    assign w_hdr_len     = {10'd0, r_ihl, 2'b00};
    assign w_hdr_final   = w_in_hdr && (r_cnt == w_hdr_len - 16'd1);
    assign w_no_payload  = (r_tlen == w_hdr_len);
    assign w_payload_end = (r_cnt == r_tlen - 16'd1);
    assign w_dst_full    = {r_dst[23:0], din};

`ifdef IPV4_CHECKSUM_EN
    // Ones-complement sum of 16-bit header words, carry folded back after every word.
    logic [15:0] r_csum;
    logic [7:0]  r_csum_hi;
    logic [15:0] w_csum_base;
    logic [16:0] w_csum_sum;
    logic [15:0] w_csum_fold;

    assign w_csum_base = (r_cnt == 16'd1) ? 16'd0 : r_csum;
    assign w_csum_sum  = {1'b0, w_csum_base} + {1'b0, r_csum_hi, din};
    assign w_csum_fold = w_csum_sum[15:0] + {15'd0, w_csum_sum[16]};
    assign w_csum_fail = (w_csum_fold != 16'hFFFF);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_csum    <= 16'd0;
            r_csum_hi <= 8'd0;
        end else if (valid && w_in_hdr) begin
            if (!r_cnt[0]) begin
                r_csum_hi <= din;
            end else begin
                r_csum <= w_csum_fold;
            end
        end
    end
`else
    assign w_csum_fail = 1'b0;
`endif

    // Each header check fires on the byte where its field is complete.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_check_fail = 1'b0;
        if (w_in_hdr) begin
            case (r_cnt)
                16'd0:   w_check_fail = (din[7:4] != 4'd4) || (din[3:0] < 4'd5);
                16'd3:   w_check_fail = ({r_tlen[15:8], din} < w_hdr_len);
                16'd7:   w_check_fail = (r_frag_hi != 6'd0) || (din != 8'd0);
                16'd9:   w_check_fail = (din != 8'd6);
                16'd19:  w_check_fail = (w_dst_full != LOCAL_IP) && (w_dst_full != BCAST_IP);
                default: w_check_fail = 1'b0;
            endcase
            if (w_hdr_final && w_csum_fail) begin
                w_check_fail = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            r_state <= S_HEADER;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (valid) begin
            case (r_state)
                S_HEADER, S_OPTIONS: begin
                    if (w_check_fail) begin
                        w_next = last ? S_HEADER : S_DROP;
                    end else if (last) begin
                        w_next = S_HEADER;
                    end else if (w_hdr_final) begin
                        w_next = w_no_payload ? S_PAD : S_PAYLOAD;
                    end else if (r_cnt == 16'd19) begin
                        w_next = S_OPTIONS;
                    end
                end
                S_PAYLOAD: begin
                    if (last) begin
                        w_next = S_HEADER;
                    end else if (w_payload_end) begin
                        w_next = S_PAD;
                    end
                end
                S_PAD, S_DROP: begin
                    if (last) begin
                        w_next = S_HEADER;
                    end
                end
                default: w_next = S_HEADER;
            endcase
        end
    end

    // A last byte ahead of total_len-1 is a truncation wherever the packet is being tracked.
    always_comb begin
        w_out_valid = 1'b0;
        w_out_last  = 1'b0;
        w_done      = 1'b0;
        w_err       = 1'b0;
        if (valid) begin
            case (r_state)
                S_HEADER, S_OPTIONS: begin
                    if (w_check_fail) begin
                        w_err = 1'b1;
                    end else if (w_hdr_final) begin
                        if (last && !w_no_payload) begin
                            w_err = 1'b1;
                        end else begin
                            w_done = 1'b1;
                        end
                    end else if (last) begin
                        w_err = 1'b1;
                    end
                end
                S_PAYLOAD: begin
                    w_out_valid = 1'b1;
                    w_out_last  = w_payload_end;
                    w_err       = last && !w_payload_end;
                end
                default: begin
                    w_out_valid = 1'b0;
                end
            endcase
        end
    end

    // Byte counter restarts on every last byte, so the next accepted byte is byte 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= 16'd0;
            r_ihl     <= 4'd0;
            r_frag_hi <= 6'd0;
            r_src     <= 32'd0;
            r_dst     <= 32'd0;
            r_tlen    <= 16'd0;
        end else if (valid) begin
            if (last) begin
                r_cnt <= 16'd0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + 16'd1;
            end
            if (w_in_hdr) begin
                case (r_cnt)
                    16'd0:                      r_ihl        <= din[3:0];
                    16'd2:                      r_tlen[15:8] <= din;
                    16'd3:                      r_tlen[7:0]  <= din;
                    16'd6:                      r_frag_hi    <= din[5:0];
                    16'd12, 16'd13, 16'd14, 16'd15: r_src    <= {r_src[23:0], din};
                    16'd16, 16'd17, 16'd18, 16'd19: r_dst    <= {r_dst[23:0], din};
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_dout      <= 8'd0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_out_valid <= w_out_valid;
            r_out_last  <= w_out_last;
            r_done      <= w_done;
            r_err       <= w_err;
            if (w_out_valid) begin
                r_dout <= din;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign dout      = r_dout;
    assign out_last  = r_out_last;
    assign src_ip    = r_src;
    assign dst_ip    = r_dst;
    assign total_len = r_tlen;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_ipv4_decode.sv
// tb_ipv4_decode: directed and randomized packets checked against a packet-level reference model.
// Compile with IPV4_CHECKSUM_EN defined to match a checksum-enabled DUT build.
module tb_ipv4_decode;

    localparam logic [31:0] LOCAL_IP = 32'hC0A80164;

    logic        clk;
    logic        rst;
    logic        valid;
    logic [7:0]  din;
    logic        last;
    logic        out_valid;
    logic [7:0]  dout;
    logic        out_last;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] total_len;
    logic        done;
    logic        err;

    ipv4_decode #(.LOCAL_IP(LOCAL_IP)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid     (valid),
        .din       (din),
        .last      (last),
        .out_valid (out_valid),
        .dout      (dout),
        .out_last  (out_last),
        .src_ip    (src_ip),
        .dst_ip    (dst_ip),
        .total_len (total_len),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned tag;
        logic [7:0]  data;
        logic        lst;
    } beat_t;

    typedef struct {
        int unsigned tag;
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] tl;
    } hdr_t;

    beat_t       exp_pay[$];
    beat_t       got_pay[$];
    hdr_t        exp_done[$];
    hdr_t        got_done[$];
    int unsigned exp_err[$];
    int unsigned got_err[$];

    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;
    int unsigned viol  = 0;

    logic [7:0]  pb [0:127];
    logic [7:0]  good_hdr [0:19];
    int          plen;
    int unsigned pkt_no;
    int unsigned cur_tag;
    int unsigned acc_tag;
    logic        acc_valid = 1'b0;
    int          gp0, gd0, ge0, ep0, ed0, ee0;
    int unsigned v0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Tag each accepted byte so its response (one cycle later) can be attributed.
    always @(posedge clk) begin
        acc_valid <= valid && rst;
        acc_tag   <= cur_tag;
    end

    always @(negedge clk) begin
        if (rst) begin
            if ((out_valid || done || err) && !acc_valid) viol++;
            if (done && err) viol++;
            if (out_last && !out_valid) viol++;
            if (out_valid) got_pay.push_back('{acc_tag, dout, out_last});
            if (done) got_done.push_back('{acc_tag, src_ip, dst_ip, total_len});
            if (err) got_err.push_back(acc_tag);
        end
    end

    function automatic logic [15:0] hdr_sum(input int hl);
        int unsigned s = 0;
        for (int w = 0; w < hl; w += 2) s += int'({pb[w], pb[w+1]});
        while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
        return 16'(s);
    endfunction

    task automatic fix_csum(input int hl);
        logic [15:0] s;
        pb[10] = 8'd0;
        pb[11] = 8'd0;
        s = hdr_sum(hl);
        {pb[10], pb[11]} = ~s;
    endtask

    task automatic build_good(input int ihl, input int npay, input int npad, input logic bcast);
        int hl, tl;
        hl = ihl * 4;
        tl = hl + npay;
        for (int i = 0; i < 128; i++) pb[i] = 8'($urandom);
        pb[0] = 8'(8'h40 | ihl);
        pb[2] = 8'(tl >> 8);
        pb[3] = 8'(tl);
        pb[6] = pb[6] & 8'h40;
        pb[7] = 8'd0;
        pb[9] = 8'd6;
        {pb[16], pb[17], pb[18], pb[19]} = bcast ? 32'hFFFFFFFF : LOCAL_IP;
        fix_csum(hl);
        plen = tl + npad;
    endtask

    task automatic load_good();
        for (int i = 0; i < 20; i++) pb[i] = good_hdr[i];
        for (int i = 0; i < 20; i++) pb[20+i] = 8'(i);
        plen = 40;
    endtask

    task automatic gen_random();
        int ihl, hl, tl, npay, m, t;
        logic [31:0] bad;
        ihl  = $urandom_range(5, 7);
        hl   = ihl * 4;
        npay = $urandom_range(0, 24);
        tl   = hl + npay;
        build_good(ihl, npay, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : 0,
                   $urandom_range(0, 3) == 0);
        m = $urandom_range(0, 12);
        case (m)
            4: pb[0] = 8'({4'($urandom_range(5, 15)), 4'(ihl)});
            5: pb[0] = 8'({4'h4, 4'($urandom_range(0, 4))});
            6: begin
                t = $urandom_range(0, hl - 1);
                pb[2] = 8'(t >> 8);
                pb[3] = 8'(t);
            end
            7: if ($urandom_range(0, 1) == 1) pb[6][5] = 1'b1;
               else pb[7] = 8'($urandom_range(1, 255));
            8: pb[9] = 8'($urandom_range(7, 255));
            9: begin
                bad = LOCAL_IP ^ (32'h1 << $urandom_range(0, 31));
                {pb[16], pb[17], pb[18], pb[19]} = bad;
            end
            default: ;
        endcase
        fix_csum(hl);
        if (m == 10) pb[11] = pb[11] ^ 8'($urandom_range(1, 255));
        if (m >= 11) plen = $urandom_range(1, tl - 1);
    endtask

    // Reference model: derives the whole expected response of one packet from its bytes.
    task automatic model_packet();
        int ihl, hl, tl, li, fail;
        logic [31:0] src, dst;
        int unsigned base;
        base = pkt_no * 256;
        ihl  = int'(pb[0] & 8'h0F);
        hl   = ihl * 4;
        tl   = int'({pb[2], pb[3]});
        li   = plen - 1;
        src  = {pb[12], pb[13], pb[14], pb[15]};
        dst  = {pb[16], pb[17], pb[18], pb[19]};
        fail = -1;
        if ((pb[0] >> 4) != 8'd4 || ihl < 5) fail = 0;
        else if (li >= 3 && tl < hl) fail = 3;
        else if (li >= 7 && (pb[6][5] || (pb[6] & 8'h1F) != 8'd0 || pb[7] != 8'd0)) fail = 7;
        else if (li >= 9 && pb[9] != 8'd6) fail = 9;
        else if (li >= 19 && dst != LOCAL_IP && dst != 32'hFFFFFFFF) fail = 19;
`ifdef IPV4_CHECKSUM_EN
        else if (li >= hl - 1 && hdr_sum(hl) != 16'hFFFF) fail = hl - 1;
`endif
        if (fail >= 0) begin
            exp_err.push_back(base + fail);
            return;
        end
        if (li < hl - 1 || (li == hl - 1 && tl > hl)) begin
            exp_err.push_back(base + li);
            return;
        end
        exp_done.push_back('{base + hl - 1, src, dst, 16'(tl)});
        for (int i = hl; i < tl && i <= li; i++) exp_pay.push_back('{base + i, pb[i], i == tl - 1});
        if (li < tl - 1) exp_err.push_back(base + li);
    endtask

    task automatic drive_packet(input int stall_pct);
        for (int i = 0; i < plen; i++) begin
            if ($urandom_range(0, 99) < stall_pct) begin
                repeat ($urandom_range(1, 2)) begin
                    valid = 1'b0;
                    din   = 8'($urandom);
                    last  = 1'($urandom);
                    @(posedge clk);
                    #1;
                end
            end
            valid   = 1'b1;
            din     = pb[i];
            last    = (i == plen - 1);
            cur_tag = pkt_no * 256 + i;
            @(posedge clk);
            #1;
        end
        valid = 1'b0;
        last  = 1'b0;
    endtask

    task automatic send(input int stall_pct);
        model_packet();
        drive_packet(stall_pct);
        pkt_no++;
    endtask

    task automatic start_batch();
        gp0 = got_pay.size();  gd0 = got_done.size(); ge0 = got_err.size();
        ep0 = exp_pay.size();  ed0 = exp_done.size(); ee0 = exp_err.size();
        v0  = viol;
    endtask

    task automatic end_batch(input string name);
        int ng, ne;
        valid = 1'b0;
        last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        ng = got_pay.size() - gp0;
        ne = exp_pay.size() - ep0;
        check({name, " beat count"}, 32'(ng), 32'(ne));
        for (int i = 0; i < ng && i < ne; i++) begin
            check({name, " beat tag"},  got_pay[gp0+i].tag,        exp_pay[ep0+i].tag);
            check({name, " beat data"}, 32'(got_pay[gp0+i].data),  32'(exp_pay[ep0+i].data));
            check({name, " beat last"}, 32'(got_pay[gp0+i].lst),   32'(exp_pay[ep0+i].lst));
        end
        ng = got_done.size() - gd0;
        ne = exp_done.size() - ed0;
        check({name, " done count"}, 32'(ng), 32'(ne));
        for (int i = 0; i < ng && i < ne; i++) begin
            check({name, " done tag"}, got_done[gd0+i].tag,     exp_done[ed0+i].tag);
            check({name, " src_ip"},   got_done[gd0+i].src,     exp_done[ed0+i].src);
            check({name, " dst_ip"},   got_done[gd0+i].dst,     exp_done[ed0+i].dst);
            check({name, " total_len"}, 32'(got_done[gd0+i].tl), 32'(exp_done[ed0+i].tl));
        end
        ng = got_err.size() - ge0;
        ne = exp_err.size() - ee0;
        check({name, " err count"}, 32'(ng), 32'(ne));
        for (int i = 0; i < ng && i < ne; i++) check({name, " err tag"}, got_err[ge0+i], exp_err[ee0+i]);
        check({name, " protocol violations"}, viol - v0, 32'd0);
    endtask

    task automatic check_cleared(input string name);
        check({name, " out_valid"}, 32'(out_valid), 32'd0);
        check({name, " dout"},      32'(dout),      32'd0);
        check({name, " out_last"},  32'(out_last),  32'd0);
        check({name, " src_ip"},    src_ip,         32'd0);
        check({name, " dst_ip"},    dst_ip,         32'd0);
        check({name, " total_len"}, 32'(total_len), 32'd0);
        check({name, " done"},      32'(done),      32'd0);
        check({name, " err"},       32'(err),       32'd0);
    endtask

    initial begin
        #600000;
        $display("FAIL timeout: bench still running, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        good_hdr = '{8'h45, 8'h00, 8'h00, 8'h28, 8'h00, 8'h01, 8'h40, 8'h00, 8'h40, 8'h06,
                     8'hB7, 8'h10, 8'hC0, 8'hA8, 8'h01, 8'h0A, 8'hC0, 8'hA8, 8'h01, 8'h64};
        rst     = 1'b0;
        valid   = 1'b0;
        last    = 1'b0;
        din     = 8'd0;
        cur_tag = 0;
        pkt_no  = 0;
        #2;
        check_cleared("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        start_batch(); load_good(); send(0); end_batch("good40");
        check("good40 held src_ip", src_ip, 32'hC0A8010A);
        check("good40 held dst_ip", dst_ip, 32'hC0A80164);
        check("good40 held total_len", 32'(total_len), 32'h0028);

        start_batch(); load_good();
        for (int i = 0; i < 6; i++) pb[40+i] = 8'hAA;
        plen = 46;
        send(0); end_batch("padded");

        start_batch(); load_good(); pb[9] = 8'h11; send(0);
        load_good(); send(0); end_batch("proto_then_good");

        start_batch(); load_good(); pb[11] = 8'h11; send(0); end_batch("bad_csum");

        start_batch(); load_good(); plen = 31; send(0); end_batch("trunc30");

        load_good();
        for (int i = 0; i < 8; i++) begin
            valid   = 1'b1;
            din     = pb[i];
            last    = 1'b0;
            cur_tag = pkt_no * 256 + i;
            @(posedge clk);
            #1;
        end
        valid = 1'b0;
        rst   = 1'b0;
        pkt_no++;
        #1;
        check_cleared("mid reset");
        repeat (2) @(posedge clk);
        #1;
        check_cleared("held reset");
        rst = 1'b1;
        start_batch(); load_good(); send(20); end_batch("after_reset");

        repeat (120) begin
            start_batch();
            repeat ($urandom_range(1, 3)) begin
                gen_random();
                send($urandom_range(0, 30));
            end
            end_batch("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
